// File: rtl/window_fetcher.sv
// -----------------------------------------------------------------------------
// window_fetcher
//
// Purpose:
//   Reader side of the window-address interface. Each single-cycle i_addr_valid
//   pulse carries one KxK window as DATA_LENGTH buffer addresses. The fetcher
//   reads them one per cycle from a single-port buffer SRAM with 1-cycle read
//   latency. It gathers the returned words and presents the whole window on
//   o_data with a single-cycle o_valid pulse.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         asynchronous active-high reset
//   i_reg_clear   synchronous clear, same effect as i_rst (lower priority)
//   i_addr_valid  address vector valid, 1-cycle pulse, accepted only when idle
//   i_addr        window addresses, index 0 fetched first
//   o_busy        fetch in progress
//   o_overrun     sticky flag: an address vector arrived while busy and was dropped
//   o_mem_re      buffer read enable
//   o_mem_addr    buffer read address
//   i_mem_data    buffer read data, valid the cycle after o_mem_re
//   o_valid       assembled window valid, 1-cycle pulse
//   o_data        assembled window, holds until the next completed window
// -----------------------------------------------------------------------------
module window_fetcher #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 9
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_reg_clear,
  input  logic                                     i_addr_valid,
  input  logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]   i_addr,
  output logic                                     o_busy,
  output logic                                     o_overrun,
  output logic                                     o_mem_re,
  output logic [ADDR_WIDTH-1:0]                    o_mem_addr,
  input  logic [DATA_WIDTH-1:0]                    i_mem_data,
  output logic                                     o_valid,
  output logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]   o_data
);

  localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                                  state_reg;
  logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  addr_reg;
  // Index of the address currently presented on o_mem_addr.
  logic [CNT_W-1:0]                        issue_cnt_reg;
  logic [CNT_W-1:0]                        issue_cnt_next;
  // Delayed copy of o_mem_re / issue index: tags the word now on i_mem_data.
  logic                                    rd_valid_reg;
  logic [CNT_W-1:0]                        rd_idx_reg;
  logic [DATA_WIDTH-1:0]                   data_reg [DATA_LENGTH];
  // Window as it will look after this edge's capture; the last word is taken
  // straight from i_mem_data so o_data updates on the same edge it returns.
  logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  window_next;

  assign issue_cnt_next = issue_cnt_reg + 1'b1;

  for (genvar gi = 0; gi < DATA_LENGTH; gi++) begin : g_window
    assign window_next[gi] = (rd_valid_reg && (rd_idx_reg == CNT_W'(gi)))
                             ? i_mem_data : data_reg[gi];
  end

  // Capture of returning words into the staging array.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DATA_LENGTH; i++) data_reg[i] <= '0;
    end else if (i_reg_clear) begin
      for (int i = 0; i < DATA_LENGTH; i++) data_reg[i] <= '0;
    end else if (rd_valid_reg) begin
      data_reg[rd_idx_reg] <= i_mem_data;
    end
  end

  // Control FSM with registered outputs. The first read is issued on the
  // accepting edge so the last word returns DATA_LENGTH+1 edges later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      rd_valid_reg  <= 1'b0;
      rd_idx_reg    <= '0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
      o_mem_re      <= 1'b0;
      o_mem_addr    <= '0;
      o_valid       <= 1'b0;
      o_data        <= '0;
    end else if (i_reg_clear) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      rd_valid_reg  <= 1'b0;
      rd_idx_reg    <= '0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
      o_mem_re      <= 1'b0;
      o_mem_addr    <= '0;
      o_valid       <= 1'b0;
      o_data        <= '0;
    end else begin
      o_valid      <= 1'b0;
      rd_valid_reg <= o_mem_re;
      rd_idx_reg   <= issue_cnt_reg;
      case (state_reg)
        S_IDLE: begin
          if (i_addr_valid) begin
            addr_reg      <= i_addr;
            issue_cnt_reg <= '0;
            o_mem_addr    <= i_addr[0];
            o_mem_re      <= 1'b1;
            o_busy        <= 1'b1;
            state_reg     <= S_READ;
          end
        end
        S_READ: begin
          if (i_addr_valid) o_overrun <= 1'b1;
          if (issue_cnt_reg == LAST_IDX) begin
            o_mem_re  <= 1'b0;
            state_reg <= S_DRAIN;
          end else begin
            issue_cnt_reg <= issue_cnt_next;
            o_mem_addr    <= addr_reg[issue_cnt_next];
          end
        end
        S_DRAIN: begin
          if (i_addr_valid) o_overrun <= 1'b1;
          o_data    <= window_next;
          o_valid   <= 1'b1;
          o_busy    <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetcher.sv
// -----------------------------------------------------------------------------
// tb_window_fetcher
//
// Self-checking bench for window_fetcher. A behavioural buffer SRAM (1-cycle
// read latency) answers the fetcher; expected windows are computed directly as
// mem[addr[k]] for every k. One line is printed per window transaction.
// -----------------------------------------------------------------------------
module tb_window_fetcher;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int DL = 9;
  localparam int EXP_LAT = DL + 1;

  typedef logic [0:DL-1][AW-1:0] addr_vec_t;
  typedef logic [0:DL-1][DW-1:0] data_vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_reg_clear = 1'b0;
  logic       i_addr_valid = 1'b0;
  addr_vec_t  i_addr = '0;
  logic       o_busy;
  logic       o_overrun;
  logic       o_mem_re;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_data;
  logic       o_valid;
  data_vec_t  o_data;

  window_fetcher #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DATA_LENGTH(DL)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_reg_clear (i_reg_clear),
    .i_addr_valid(i_addr_valid),
    .i_addr      (i_addr),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_mem_re    (o_mem_re),
    .o_mem_addr  (o_mem_addr),
    .i_mem_data  (i_mem_data),
    .o_valid     (o_valid),
    .o_data      (o_data)
  );

  always #5 i_clk = ~i_clk;

  // Buffer SRAM model: registered read, data valid the cycle after the enable.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] mem_rdata = '0;
  always @(posedge i_clk) if (o_mem_re) mem_rdata <= mem[o_mem_addr];
  assign i_mem_data = mem_rdata;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent window.
  int            obs_lat;
  int            obs_first;
  int            obs_last;
  bit            obs_stable;
  data_vec_t     obs_data;
  logic [AW-1:0] obs_addr [$];

  function automatic data_vec_t model(input addr_vec_t a);
    data_vec_t r;
    for (int k = 0; k < DL; k++) r[k] = mem[a[k]];
    return r;
  endfunction

  function automatic addr_vec_t rand_addr();
    addr_vec_t r;
    for (int k = 0; k < DL; k++) r[k] = AW'($urandom_range(0, 63));
    return r;
  endfunction

  // Called at a negedge with i_addr/i_addr_valid already set up for acceptance.
  // Records the read stream and returns at the negedge where o_valid is seen.
  // inject_at >= 0 presents inject_addr for one cycle while the fetch runs.
  task automatic collect(input int inject_at, input addr_vec_t inject_addr);
    data_vec_t held;
    held = o_data;
    obs_addr.delete();
    obs_first  = -1;
    obs_last   = -1;
    obs_stable = 1'b1;
    obs_lat    = -1;
    @(negedge i_clk);
    i_addr_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_mem_re) begin
        obs_addr.push_back(o_mem_addr);
        if (obs_first < 0) obs_first = c;
        obs_last = c;
      end
      if (o_valid) begin
        obs_lat  = c;
        obs_data = o_data;
        return;
      end
      if (o_data !== held) obs_stable = 1'b0;
      if (c == inject_at) begin
        i_addr       = inject_addr;
        i_addr_valid = 1'b1;
      end else begin
        i_addr_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    i_addr_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++; if ({o_busy, o_overrun, o_mem_re, o_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_overrun, o_mem_re, o_valid});
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_mem_addr !== '0) begin
      errors++; $display("FAIL reset_mem_addr: got %h expected 00", o_mem_addr);
    end
    checks++; if (o_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", o_data);
    end
  endtask

  task automatic test_single_window();
    addr_vec_t a;
    data_vec_t exp_c;
    a     = {6'd0, 6'd1, 6'd2, 6'd8, 6'd9, 6'd10, 6'd16, 6'd17, 6'd18};
    exp_c = {8'h40, 8'h41, 8'h42, 8'h48, 8'h49, 8'h4A, 8'h50, 8'h51, 8'h52};
    for (int i = 0; i < 64; i++) mem[i] = DW'(i + 8'h40);
    i_addr = a; i_addr_valid = 1'b1;
    collect(-1, '0);
    $display("single window lat=%0d data=%h", obs_lat, obs_data);
    checks++; if (obs_lat !== EXP_LAT) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", obs_lat, EXP_LAT);
    end
    checks++; if (obs_addr.size() !== DL || obs_first !== 0 || obs_last !== DL - 1) begin
      errors++; $display("FAIL single_read_run: got n=%0d first=%0d last=%0d expected n=%0d first=0 last=%0d",
                         obs_addr.size(), obs_first, obs_last, DL, DL - 1);
    end
    for (int k = 0; k < obs_addr.size() && k < DL; k++) begin
      checks++; if (obs_addr[k] !== a[k]) begin
        errors++; $display("FAIL single_addr[%0d]: got %0d expected %0d", k, obs_addr[k], a[k]);
      end
    end
    checks++; if (obs_data !== exp_c) begin
      errors++; $display("FAIL single_data: got %h expected %h", obs_data, exp_c);
    end
    checks++; if (o_busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_at_valid: got %b expected 0", o_busy);
    end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0 || o_data !== exp_c) begin
      errors++; $display("FAIL single_pulse_hold: got valid=%b data=%h expected valid=0 data=%h", o_valid, o_data, exp_c);
    end
  endtask

  task automatic test_overrun();
    addr_vec_t a;
    data_vec_t exp_w;
    a     = {6'd0, 6'd1, 6'd2, 6'd8, 6'd9, 6'd10, 6'd16, 6'd17, 6'd18};
    exp_w = model(a);
    checks++; if (o_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_initial: got %b expected 0", o_overrun);
    end
    i_addr = a; i_addr_valid = 1'b1;
    collect(3, rand_addr());
    $display("overrun window lat=%0d data=%h overrun=%b", obs_lat, obs_data, o_overrun);
    checks++; if (obs_lat !== EXP_LAT || obs_data !== exp_w) begin
      errors++; $display("FAIL overrun_window: got lat=%0d data=%h expected lat=%0d data=%h", obs_lat, obs_data, EXP_LAT, exp_w);
    end
    checks++; if (o_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b expected 1", o_overrun);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge i_clk);
      checks++; if (o_valid !== 1'b0 || o_mem_re !== 1'b0 || o_overrun !== 1'b1) begin
        errors++; $display("FAIL overrun_dropped c=%0d: got valid=%b re=%b overrun=%b expected 0 0 1", c, o_valid, o_mem_re, o_overrun);
      end
    end
  endtask

  task automatic test_clear();
    addr_vec_t a;
    a = rand_addr();
    i_addr = a; i_addr_valid = 1'b1;
    @(negedge i_clk);
    i_addr_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++; if (o_mem_re !== 1'b1 || o_mem_addr !== a[4]) begin
      errors++; $display("FAIL clear_pre: got re=%b addr=%0d expected re=1 addr=%0d", o_mem_re, o_mem_addr, a[4]);
    end
    i_reg_clear = 1'b1;
    @(negedge i_clk);
    i_reg_clear = 1'b0;
    checks++; if ({o_mem_re, o_busy, o_overrun, o_valid} !== 4'b0 || o_data !== '0) begin
      errors++; $display("FAIL clear_effect: got re/busy/ovr/valid=%b data=%h expected 0000 data=0",
                         {o_mem_re, o_busy, o_overrun, o_valid}, o_data);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge i_clk);
      checks++; if (o_valid !== 1'b0 || o_mem_re !== 1'b0) begin
        errors++; $display("FAIL clear_quiet c=%0d: got valid=%b re=%b expected 0 0", c, o_valid, o_mem_re);
      end
    end
    a = rand_addr();
    i_addr = a; i_addr_valid = 1'b1;
    collect(-1, '0);
    $display("post-clear window lat=%0d data=%h", obs_lat, obs_data);
    checks++; if (obs_lat !== EXP_LAT || obs_data !== model(a)) begin
      errors++; $display("FAIL clear_recover: got lat=%0d data=%h expected lat=%0d data=%h", obs_lat, obs_data, EXP_LAT, model(a));
    end
  endtask

  task automatic test_back_to_back();
    addr_vec_t a1, a2;
    data_vec_t w1;
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    a1 = rand_addr();
    a2 = rand_addr();
    @(negedge i_clk);
    i_addr = a1; i_addr_valid = 1'b1;
    collect(-1, '0);
    w1 = obs_data;
    $display("b2b window1 lat=%0d data=%h", obs_lat, obs_data);
    checks++; if (w1 !== model(a1)) begin
      errors++; $display("FAIL b2b_w1: got %h expected %h", w1, model(a1));
    end
    i_addr = a2; i_addr_valid = 1'b1;
    collect(-1, '0);
    $display("b2b window2 lat=%0d data=%h", obs_lat, obs_data);
    checks++; if (obs_stable !== 1'b1) begin
      errors++; $display("FAIL b2b_hold: got stable=%b expected 1", obs_stable);
    end
    checks++; if (obs_lat !== EXP_LAT || obs_data !== model(a2)) begin
      errors++; $display("FAIL b2b_w2: got lat=%0d data=%h expected lat=%0d data=%h", obs_lat, obs_data, EXP_LAT, model(a2));
    end
  endtask

  task automatic test_boundary();
    addr_vec_t a;
    data_vec_t exp_ff;
    a      = {DL{6'd63}};
    exp_ff = {DL{8'hFF}};
    mem[63] = 8'hFF;
    @(negedge i_clk);
    i_addr = a; i_addr_valid = 1'b1;
    collect(-1, '0);
    $display("boundary window lat=%0d data=%h", obs_lat, obs_data);
    checks++; if (obs_addr.size() !== DL) begin
      errors++; $display("FAIL boundary_count: got %0d expected %0d", obs_addr.size(), DL);
    end
    for (int k = 0; k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== 6'd63) begin
        errors++; $display("FAIL boundary_addr[%0d]: got %0d expected 63", k, obs_addr[k]);
      end
    end
    checks++; if (obs_data !== exp_ff) begin
      errors++; $display("FAIL boundary_data: got %h expected %h", obs_data, exp_ff);
    end
  endtask

  task automatic test_async_reset();
    @(negedge i_clk);
    checks++; if (o_data === '0) begin
      errors++; $display("FAIL areset_precond: got data=%h expected nonzero", o_data);
    end
    i_addr = rand_addr(); i_addr_valid = 1'b1;
    @(negedge i_clk);
    i_addr_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    checks++; if ({o_mem_re, o_valid, o_busy} !== 3'b0 || o_data !== '0) begin
      errors++; $display("FAIL areset_immediate: got re/valid/busy=%b data=%h expected 000 data=0",
                         {o_mem_re, o_valid, o_busy}, o_data);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge i_clk);
      checks++; if (o_valid !== 1'b0 || o_mem_re !== 1'b0) begin
        errors++; $display("FAIL areset_quiet c=%0d: got valid=%b re=%b expected 0 0", c, o_valid, o_mem_re);
      end
    end
  endtask

  task automatic test_random();
    addr_vec_t a;
    int gap;
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    for (int w = 0; w < 16; w++) begin
      gap = (w == 0) ? 1 : $urandom_range(0, 2);
      repeat (gap) @(negedge i_clk);
      a = rand_addr();
      i_addr = a; i_addr_valid = 1'b1;
      collect(-1, '0);
      $display("random window %0d gap=%0d lat=%0d data=%h", w, gap, obs_lat, obs_data);
      checks++; if (obs_lat !== EXP_LAT) begin
        errors++; $display("FAIL rand_latency w=%0d: got %0d expected %0d", w, obs_lat, EXP_LAT);
      end
      checks++; if (obs_addr.size() !== DL || obs_last - obs_first !== DL - 1) begin
        errors++; $display("FAIL rand_read_run w=%0d: got n=%0d span=%0d expected n=%0d span=%0d",
                           w, obs_addr.size(), obs_last - obs_first, DL, DL - 1);
      end
      for (int k = 0; k < obs_addr.size() && k < DL; k++) begin
        checks++; if (obs_addr[k] !== a[k]) begin
          errors++; $display("FAIL rand_addr w=%0d k=%0d: got %0d expected %0d", w, k, obs_addr[k], a[k]);
        end
      end
      checks++; if (obs_data !== model(a)) begin
        errors++; $display("FAIL rand_data w=%0d: got %h expected %h", w, obs_data, model(a));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_single_window();
    test_overrun();
    test_clear();
    test_back_to_back();
    test_boundary();
    test_async_reset();
    test_random();
    repeat (2) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
